buf_packer: RTL and testbench
=============================

BUF_PACKER -- requirements
Module: buf_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-address width of the downstream buffer (depth 2**ADDR_W words).
REQ-002 SHALL have parameter WRAP, default 0, meaning 0 = stop at full, 1 = wrap address to 0.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a pulse that arms capture and clears the address, count and flags.
REQ-007 SHALL have port in_valid, input, 1, meaning the byte-stream valid signal.
REQ-008 SHALL have port in_ready, output, 1, meaning the byte-stream ready signal; a byte is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data, input, 8, meaning the stream byte.
REQ-010 SHALL have port in_last, input, 1, meaning the final byte of a capture; it forces a flush of the partial word.
REQ-011 SHALL have port wren, output, 1, meaning the buffer write enable.
REQ-012 SHALL have port address, output, ADDR_W, meaning the buffer word address.
REQ-013 SHALL have port data, output, 32, meaning the buffer write word.
REQ-014 SHALL have port busy, output, 1, meaning high in PACK and FULL.
REQ-015 SHALL have port full, output, 1, meaning high in FULL.
REQ-016 SHALL have port overflow, output, 1, meaning a sticky flag for bytes discarded while full.
REQ-017 SHALL have port word_count, output, ADDR_W+1, meaning the number of words written since start, saturating at 2**ADDR_W.

Function
REQ-018 SHALL implement states IDLE, PACK and FULL.
REQ-019 SHALL hold in_ready at 0 in IDLE and at 1 in PACK and FULL.
REQ-020 SHALL, on start in any state, go to PACK; clear the write pointer, lane, word_count and overflow; and discard any partial word.
REQ-021 SHALL, when start and an accepted byte coincide, give start priority and discard the byte.
REQ-022 SHALL, in PACK, place the accepted byte into data lane "lane" (bits 8*lane+7..8*lane, little-endian), where lane counts 0 to 3.
REQ-023 SHALL, when the lane-3 byte or an in_last byte is accepted, register a write: wren=1 for exactly one cycle, on the next cycle, with address equal to the current write pointer.
REQ-024 SHALL write zeros in the unfilled lanes of a partial (in_last) word.
REQ-025 SHALL sustain 1 byte per cycle with no stall; the assembly register is separate from the output registers.
REQ-026 SHALL, after each write, increment the pointer (modulo 2**ADDR_W) and increment word_count (saturating).
REQ-027 SHALL, when in_last is accepted, go to IDLE after issuing its write; a following start re-arms capture.
REQ-028 SHALL, with WRAP=0, enter FULL when the write to address 2**ADDR_W-1 is issued.
REQ-029 SHALL, in FULL, accept and discard bytes, set overflow on the first such byte, issue no writes, and leave FULL only on start or reset.
REQ-030 SHALL, with WRAP=1, never enter FULL; the pointer wraps to 0 and word_count saturates.
REQ-031 SHALL, with in_last on a lane-3 byte, issue exactly one write.
REQ-032 SHALL hold address and data stable while wren=0.

Reset
REQ-033 SHALL, on reset assertion, set state=IDLE, in_ready=0, wren=0, address=0, data=0, lane=0, word_count=0, full=0, overflow=0, busy=0.
REQ-034 SHALL, when reset occurs mid-word, lose the partial word with no write.

Structure
REQ-035 SHALL take the state enum, the constant BYTES_PER_WORD=4 and the default ADDR_W=14 from the shared package buf_pkg.
REQ-036 SHALL be a single module with no sub-module; the bench instantiates buf0 downstream.

Verification
REQ-037 SHALL cover: start, then bytes 11 22 33 44 -> one write at address 0, data 0x44332211, word_count=1.
REQ-038 SHALL cover: start, then bytes AA BB with in_last on BB -> a write at address 0, data 0x0000BBAA, followed by IDLE and in_ready=0.
REQ-039 SHALL cover: 65536 back-to-back bytes with WRAP=0 -> 16384 writes at addresses 0..16383, full=1; a further byte -> overflow=1 and no write.
REQ-040 SHALL cover: WRAP=1 with 65540 bytes -> the final write at address 0, word_count=16384.
REQ-041 SHALL cover: start asserted after 2 bytes -> no write; the next 4 bytes are written at address 0.
REQ-042 SHALL cover: reset pulse mid-word -> all outputs return to their reset values and no wren pulse occurs.

Source files
------------

// File: rtl/buf_pkg.sv
// Shared definitions for the byte-to-word buffer packer.
package buf_pkg;

    // Capture state: waiting for start, packing bytes, or buffer exhausted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_ADDR_W = 14;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/buf_packer.sv
// Packs a valid/ready byte stream into little-endian 32-bit words and writes
// them to a word-addressed buffer. A capture is armed by start and finishes on
// in_last (flushing any partial word) or, without wrap, when the buffer fills.
//
// Handshake: a byte transfers on a rising clock edge where in_valid and
// in_ready are both high; in_ready depends only on the registered state, and
// the producer may hold in_valid high for consecutive bytes (one per cycle).
module buf_packer
    import buf_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WRAP   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              wren,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data,
    output logic              busy,
    output logic              full,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        state_dbg_o
);

    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic                accept;
    logic [31:0]         word;

    assign in_ready    = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign full        = (state_q == ST_FULL);
    assign accept      = in_valid && in_ready;
    assign wren        = wren_q;
    assign address     = addr_q;
    assign data        = data_q;
    assign overflow    = ovf_q;
    assign word_count  = count_q;
    assign state_dbg_o = state_q;

    // State and datapath registers; reset drops any partial word silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            asm_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: start wins over everything, then per-state packing.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        // The assembly register is kept zero above the current lane, so
        // merging the new byte also zero-fills the lanes of a partial word.
        word = asm_q;
        word[{lane_q, 3'b000} +: 8] = in_data;

        if (start) begin
            state_d = ST_PACK;
            lane_d  = '0;
            asm_d   = '0;
            ptr_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_PACK: begin
                    if (accept) begin
                        if (lane_q == LANE_LAST || in_last) begin
                            wren_d  = 1'b1;
                            addr_d  = ptr_q;
                            data_d  = word;
                            ptr_d   = ptr_q + 1'b1;
                            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
                            asm_d   = '0;
                            lane_d  = '0;
                            // Running out of buffer outranks end of capture.
                            if (WRAP == 0 && ptr_q == PTR_LAST) begin
                                state_d = ST_FULL;
                            end else if (in_last) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            asm_d  = word;
                            lane_d = lane_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Bytes keep draining so the source never stalls.
                    if (accept) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_packer.sv
// Bench for buf_packer: one stop-at-full instance and one wrapping instance,
// each with a write scoreboard fed by the stimulus drivers.
module tb_buf_packer;
    localparam int AW = 14;

    logic clock;
    logic reset;

    logic          start0, in_valid0, in_last0, in_ready0, wren0, busy0, full0, ovf0;
    logic [7:0]    in_data0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic [AW:0]   cnt0;
    logic [1:0]    st0;

    logic          start1, in_valid1, in_last1, in_ready1, wren1, busy1, full1, ovf1;
    logic [7:0]    in_data1;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata1;
    logic [AW:0]   cnt1;
    logic [1:0]    st1;

    logic [AW+31:0] exp0_q[$];
    logic [AW+31:0] exp1_q[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic        last;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[5];

    logic [31:0] w0, w1;
    logic [7:0]  b0, b1;

    buf_packer #(.ADDR_W(AW), .WRAP(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_last(in_last0),
        .wren(wren0), .address(addr0), .data(wdata0), .busy(busy0), .full(full0),
        .overflow(ovf0), .word_count(cnt0), .state_dbg_o(st0)
    );

    buf_packer #(.ADDR_W(AW), .WRAP(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .wren(wren1), .address(addr1), .data(wdata1), .busy(busy1), .full(full1),
        .overflow(ovf1), .word_count(cnt1), .state_dbg_o(st1)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send0(input logic [7:0] b, input logic l);
        @(negedge clock);
        in_valid0 = 1'b1;
        in_data0  = b;
        in_last0  = l;
        @(posedge clock);
        #1;
        in_valid0 = 1'b0;
        in_last0  = 1'b0;
    endtask

    task automatic start_pulse0();
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
    endtask

    // Scoreboards: every observed write must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && wren0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr0 unexpected write addr %0h data %0h", addr0, wdata0);
            end else begin
                chk("wr0", {addr0, wdata0}, exp0_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && wren1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr1 unexpected write addr %0h data %0h", addr1, wdata1);
            end else begin
                chk("wr1", {addr1, wdata1}, exp1_q.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, in_ready0, 0);
        chk({tag, " wren"},     wren0, 0);
        chk({tag, " address"},  addr0, 0);
        chk({tag, " data"},     wdata0, 0);
        chk({tag, " count"},    cnt0, 0);
        chk({tag, " full"},     full0, 0);
        chk({tag, " overflow"}, ovf0, 0);
        chk({tag, " busy"},     busy0, 0);
        chk({tag, " state"},    st0, 0);
    endtask

    initial begin
        reset = 1'b1;
        start0 = 0; in_valid0 = 0; in_last0 = 0; in_data0 = 0;
        start1 = 0; in_valid1 = 0; in_last1 = 0; in_data1 = 0;

        vecs[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 1'b1, 2'd1};
        vecs[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 1'b0, 2'd0};
        vecs[2] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 1'b0, 2'd0};
        vecs[3] = '{32'h04030201, 4, 1'b1, 32'h04030201, 1'b0, 2'd0};
        vecs[4] = '{32'h0077DEC0, 3, 1'b1, 32'h0077DEC0, 1'b0, 2'd0};

        // Reset state
        repeat (2) @(negedge clock);
        chk_reset_outputs("por");
        chk("por dut1 busy", busy1, 0);
        chk("por dut1 count", cnt1, 0);
        @(negedge clock);
        reset = 1'b0;

        // Table of single-word captures, each armed by a fresh start
        for (int v = 0; v < 5; v++) begin
            start_pulse0();
            chk($sformatf("v%0d ready after start", v), in_ready0, 1);
            exp0_q.push_back({{AW{1'b0}}, vecs[v].exp_data});
            for (int k = 0; k < vecs[v].n; k++) begin
                logic [31:0] bs;
                bs = vecs[v].bytes;
                send0(bs[8*k +: 8], vecs[v].last && (k == vecs[v].n - 1));
            end
            repeat (2) @(negedge clock);
            chk($sformatf("v%0d drained", v), 64'(exp0_q.size()), 0);
            chk($sformatf("v%0d count", v), cnt0, 1);
            chk($sformatf("v%0d address", v), addr0, 0);
            chk($sformatf("v%0d ready", v), in_ready0, vecs[v].exp_ready);
            chk($sformatf("v%0d state", v), st0, vecs[v].exp_state);
        end

        // Start after two bytes discards them; the next word lands at 0
        start_pulse0();
        send0(8'h11, 1'b0);
        send0(8'h22, 1'b0);
        start_pulse0();
        exp0_q.push_back({{AW{1'b0}}, 32'hA4A3A2A1});
        send0(8'hA1, 1'b0);
        send0(8'hA2, 1'b0);
        send0(8'hA3, 1'b0);
        send0(8'hA4, 1'b0);
        repeat (2) @(negedge clock);
        chk("restart drained", 64'(exp0_q.size()), 0);
        chk("restart count", cnt0, 1);
        chk("restart address", addr0, 0);

        // Start coinciding with an accepted byte wins and drops the byte
        @(negedge clock);
        start0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hFF;
        @(posedge clock);
        #1;
        start0 = 1'b0; in_valid0 = 1'b0;
        exp0_q.push_back({{AW{1'b0}}, 32'h04030201});
        send0(8'h01, 1'b0);
        send0(8'h02, 1'b0);
        send0(8'h03, 1'b0);
        send0(8'h04, 1'b0);
        repeat (2) @(negedge clock);
        chk("prio drained", 64'(exp0_q.size()), 0);
        chk("prio count", cnt0, 1);
        chk("prio data", wdata0, 32'h04030201);

        // Reset in the middle of a word: no write, everything back to zero
        start_pulse0();
        send0(8'h55, 1'b0);
        send0(8'h66, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk_reset_outputs("postrst");

        // Fill the whole buffer (stop at full) and wrap the other instance
        fork
            begin
                start_pulse0();
                w0 = '0;
                for (int i = 0; i < 65536; i++) begin
                    b0 = 8'($urandom_range(0, 255));
                    w0[8*(i%4) +: 8] = b0;
                    if (i % 4 == 3) begin
                        exp0_q.push_back({AW'(i / 4), w0});
                        w0 = '0;
                    end
                    send0(b0, 1'b0);
                end
                repeat (2) @(negedge clock);
                chk("fill drained", 64'(exp0_q.size()), 0);
                chk("fill full", full0, 1);
                chk("fill busy", busy0, 1);
                chk("fill ready", in_ready0, 1);
                chk("fill count", cnt0, 64'd16384);
                chk("fill state", st0, 2);
                chk("fill overflow before", ovf0, 0);
                send0(8'h99, 1'b0);
                repeat (2) @(negedge clock);
                chk("fill overflow after", ovf0, 1);
                chk("fill still full", full0, 1);
                chk("fill count held", cnt0, 64'd16384);
            end
            begin
                @(negedge clock);
                start1 = 1'b1;
                @(posedge clock);
                #1;
                start1 = 1'b0;
                w1 = '0;
                for (int j = 0; j < 65540; j++) begin
                    b1 = 8'($urandom_range(0, 255));
                    w1[8*(j%4) +: 8] = b1;
                    if (j % 4 == 3) begin
                        exp1_q.push_back({AW'(j / 4), w1});
                        w1 = '0;
                    end
                    @(negedge clock);
                    in_valid1 = 1'b1;
                    in_data1  = b1;
                    @(posedge clock);
                    #1;
                    in_valid1 = 1'b0;
                end
                repeat (2) @(negedge clock);
                chk("wrap drained", 64'(exp1_q.size()), 0);
                chk("wrap last address", addr1, 0);
                chk("wrap count", cnt1, 64'd16384);
                chk("wrap full", full1, 0);
                chk("wrap overflow", ovf1, 0);
                chk("wrap state", st1, 1);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
